scratch_pad_loader: RTL and testbench
=====================================

Name: scratch_pad_loader

Overview:
- Writer-side sequencer that drives the scratch-pad write port (step, bram_num, bram_addr, bram_layer, data_received) from a valid/ready stream of 32-bit words.
- On each command it fills every activation BRAM or every weight BRAM in a fixed nested order, then reports completion.
- Sits between the host/DMA receive path and the scratch pad inside the NDP unit.

Parameters:
- BUFFER_SIZE, 5, layers per BRAM; each layer is 2 words, so BRAM depth = BUFFER_SIZE*2.
- SYS_WIDTH, 64, number of weight BRAMs.
- SYS_HEIGHT, 1, number of activation BRAMs.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- load_weight  in  1  sampled with start: 0 = activation load, 1 = weight load.
- abort  in  1  cancels the current load.
- s_valid  in  1  input word valid.
- s_data  in  32  input word.
- s_ready  out  1  loader accepts a word this cycle.
- step  out  3  write-port step: 0 idle, 1 activation write, 2 weight write.
- bram_num  out  6  target BRAM index.
- bram_addr  out  1  word within layer.
- bram_layer  out  3  layer index.
- data_received  out  32  write data.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse after the last word's write cycle.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- States:
  - IDLE: start=1 -> LOAD, with mode latched from load_weight. Otherwise stay.
  - LOAD: s_ready=1. Each handshake (s_valid & s_ready) advances the counters. The last handshake -> FINISH. abort=1 -> IDLE.
  - FINISH: one cycle, done=1 -> IDLE.
- busy is 1 in LOAD and FINISH.
- Counter order, innermost first:
  - bram_addr 0..1.
  - bram_layer 0..BUFFER_SIZE-1.
  - bram_num 0..N-1, where N = SYS_HEIGHT for activation and SYS_WIDTH for weight.
  - Each counter wraps to 0 and carries into the next.
  - Last word: addr=1, layer=BUFFER_SIZE-1, num=N-1.
- Word totals: N*BUFFER_SIZE*2. Defaults give 10 words for activation and 640 for weight.
- Write outputs are registered, with 1-cycle latency. In the cycle after a handshake:
  - step = 1 or 2 by mode.
  - bram_num, bram_addr and bram_layer carry the pre-increment counter values.
  - data_received = the accepted word.
- step = 0 in every cycle not directly following a handshake, including LOAD cycles with s_valid=0. This means no spurious scratch-pad writes occur.
- bram_num, bram_addr, bram_layer and data_received hold their last values while step = 0.
- done asserts in the same cycle as the final write strobe. FINISH is entered on the last handshake, so the final strobe and done coincide.
- start while busy: ignored.
- start in the same cycle as FINISH: ignored. A new start is accepted from IDLE, i.e. one cycle after done.
- abort:
  - Priority over a simultaneous handshake: the word is not accepted and s_ready is forced to 0 that cycle.
  - Next cycle: IDLE with counters cleared.
  - A write strobe already registered from the previous cycle still completes.
- abort in IDLE or FINISH: no effect. done still pulses in FINISH.
- Reset mid-load: immediate return to IDLE, step=0, no done.

Optional Feature:
- Macro: SCRATCH_PAD_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum[31:0]: a 32-bit wrapping sum of all words accepted in the current load.
  - Cleared on start acceptance and on reset.
  - Valid from the done cycle and held until the next start.
  - Not updated on the handshake cycle blocked by abort.
- When undefined: no port and no logic.

Decomposition:
- Shared package scratch_pad_pkg:
  - STEP_IDLE=3'd0, STEP_ACT=3'd1, STEP_WGT=3'd2.
  - Loader state encodings IDLE/LOAD/FINISH.
  - BRAM_NUM_W=6, BRAM_LAYER_W=3.
- One sub-module, loader_addr_counter:
  - Nested addr/layer/num counter with a runtime limit N.
  - Inputs: clear, advance.
  - Outputs: the three indices and last.

Test Plan:
- Activation load, s_valid held high, words 0x100..0x109:
  - 10 strobes with step=1, bram_num=0.
  - (layer,addr) sequence (0,0),(0,1),(1,0)…(4,1).
  - done coincides with the 0x109 write; busy drops the next cycle.
- Weight load with s_valid toggling every other cycle:
  - 640 strobes with step=2.
  - bram_num steps 0..63 every 10 words.
  - step=0 in every gap cycle.
  - Last strobe: num=63, layer=4, addr=1.
- abort asserted on word 5 of an activation load, with s_valid high:
  - word 5 is not accepted; strobes for words 0..4 only.
  - IDLE next cycle, no done.
  - Restarted load begins again at layer 0, addr 0.
- start pulsed during a weight load and again on the done cycle:
  - both ignored; exactly one done.
  - start one cycle later is accepted.
- rst_n asserted mid-load at word 3:
  - outputs 0 immediately.
  - After release, s_ready=0 until the next start.
- With SCRATCH_PAD_LOADER_CHECKSUM_EN, activation words 1..10:
  - checksum = 55 at done.
  - checksum = 0 after the next start.

Source files
------------

// File: rtl/scratch_pad_pkg.sv
// scratch_pad_pkg: shared step codes, loader states and index widths for the scratch-pad write path
package scratch_pad_pkg;
  localparam logic [2:0] STEP_IDLE = 3'd0;
  localparam logic [2:0] STEP_ACT = 3'd1;
  localparam logic [2:0] STEP_WGT = 3'd2;
  localparam int BRAM_NUM_W = 6;
  localparam int BRAM_LAYER_W = 3;
  typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;
endpackage

// File: rtl/scratch_pad_loader_addr_counter.sv
// loader_addr_counter: nested addr/layer/num index counter with runtime num limit; ports clk, rst_n, i_clear, i_advance, i_num_max -> o_addr, o_layer, o_num, o_last
module loader_addr_counter import scratch_pad_pkg::*; #(
  parameter int BUFFER_SIZE = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clear,
  input  logic                    i_advance,
  input  logic [BRAM_NUM_W-1:0]   i_num_max,
  output logic                    o_addr,
  output logic [BRAM_LAYER_W-1:0] o_layer,
  output logic [BRAM_NUM_W-1:0]   o_num,
  output logic                    o_last
);
  logic                    r_addr;
  logic [BRAM_LAYER_W-1:0] r_layer;
  logic [BRAM_NUM_W-1:0]   r_num;
  logic                    w_layer_last;
  logic                    w_num_last;
  assign w_layer_last = r_layer == BRAM_LAYER_W'(BUFFER_SIZE - 1);
  assign w_num_last = r_num == i_num_max;
  assign o_last = r_addr && w_layer_last && w_num_last;
  assign o_addr = r_addr;
  assign o_layer = r_layer;
  assign o_num = r_num;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_addr <= 1'b0;
      r_layer <= '0;
      r_num <= '0;
    end else if (i_clear) begin
      r_addr <= 1'b0;
      r_layer <= '0;
      r_num <= '0;
    end else if (i_advance) begin
      r_addr <= ~r_addr;
      if (r_addr) begin
        r_layer <= w_layer_last ? '0 : r_layer + 1'b1;
        if (w_layer_last) r_num <= w_num_last ? '0 : r_num + 1'b1;
      end
    end
endmodule

// File: rtl/scratch_pad_loader.sv
// scratch_pad_loader: sequences a valid/ready word stream onto the scratch-pad write port (step/bram_num/bram_addr/bram_layer/data_received) with busy/done; optional checksum output under SCRATCH_PAD_LOADER_CHECKSUM_EN
module scratch_pad_loader import scratch_pad_pkg::*; #(
  parameter int BUFFER_SIZE = 5,
  parameter int SYS_WIDTH = 64,
  parameter int SYS_HEIGHT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    load_weight,
  input  logic                    abort,
  input  logic                    s_valid,
  input  logic [31:0]             s_data,
  output logic                    s_ready,
  output logic [2:0]              step,
  output logic [BRAM_NUM_W-1:0]   bram_num,
  output logic                    bram_addr,
  output logic [BRAM_LAYER_W-1:0] bram_layer,
  output logic [31:0]             data_received,
`ifdef SCRATCH_PAD_LOADER_CHECKSUM_EN
  output logic [31:0]             checksum,
`endif
  output logic                    busy,
  output logic                    done
);
  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_mode;
  logic                    w_hs;
  logic                    w_addr;
  logic [BRAM_LAYER_W-1:0] w_layer;
  logic [BRAM_NUM_W-1:0]   w_num;
  logic                    w_last;
  logic [2:0]              r_step;
  logic [BRAM_NUM_W-1:0]   r_num;
  logic                    r_addr;
  logic [BRAM_LAYER_W-1:0] r_layer;
  logic [31:0]             r_data;
  // abort wins over a simultaneous valid word, so it also gates ready
  assign s_ready = r_state == LOAD && !abort;
  assign w_hs = s_ready && s_valid;
  assign busy = r_state != IDLE;
  // FINISH is entered on the last handshake, so done lines up with the final strobe
  assign done = r_state == FINISH;
  assign step = r_step;
  assign bram_num = r_num;
  assign bram_addr = r_addr;
  assign bram_layer = r_layer;
  assign data_received = r_data;
  loader_addr_counter #(.BUFFER_SIZE(BUFFER_SIZE)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (r_state != LOAD || abort),
    .i_advance(w_hs),
    .i_num_max(r_mode ? BRAM_NUM_W'(SYS_WIDTH - 1) : BRAM_NUM_W'(SYS_HEIGHT - 1)),
    .o_addr   (w_addr),
    .o_layer  (w_layer),
    .o_num    (w_num),
    .o_last   (w_last)
  );
  always_comb begin
    w_state_next = r_state;
    if (r_state == IDLE && start) w_state_next = LOAD;
    else if (r_state == LOAD && abort) w_state_next = IDLE;
    else if (w_hs && w_last) w_state_next = FINISH;
    else if (r_state == FINISH) w_state_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_mode <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && start) r_mode <= load_weight;
    end
  // write strobe is a single cycle; indices and data hold while step is idle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_step <= STEP_IDLE;
      r_num <= '0;
      r_addr <= 1'b0;
      r_layer <= '0;
      r_data <= '0;
    end else begin
      r_step <= w_hs ? (r_mode ? STEP_WGT : STEP_ACT) : STEP_IDLE;
      if (w_hs) begin
        r_num <= w_num;
        r_addr <= w_addr;
        r_layer <= w_layer;
        r_data <= s_data;
      end
    end
`ifdef SCRATCH_PAD_LOADER_CHECKSUM_EN
  logic [31:0] r_sum;
  assign checksum = r_sum;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sum <= '0;
    else if (r_state == IDLE && start) r_sum <= '0;
    else if (w_hs) r_sum <= r_sum + s_data;
`endif
endmodule

// File: tb/tb_scratch_pad_loader.sv
// tb_scratch_pad_loader: randomized directed bench checking scratch_pad_loader against an index-arithmetic reference model
module tb_scratch_pad_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        load_weight = 1'b0;
  logic        abort = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic [2:0]  step;
  logic [5:0]  bram_num;
  logic        bram_addr;
  logic [2:0]  bram_layer;
  logic [31:0] data_received;
  logic        busy;
  logic        done;
`ifdef SCRATCH_PAD_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif
  int checks = 0;
  int errors = 0;
  int m_phase = 0;
  int m_k = 0;
  int done_cnt = 0;
  logic        m_mode = 1'b0;
  logic [31:0] m_sum = '0;
  int e_step = 0;
  int e_num = 0;
  int e_layer = 0;
  int e_addr = 0;
  logic [31:0] e_data = '0;
  scratch_pad_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .load_weight  (load_weight),
    .abort        (abort),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .step         (step),
    .bram_num     (bram_num),
    .bram_addr    (bram_addr),
    .bram_layer   (bram_layer),
    .data_received(data_received),
`ifdef SCRATCH_PAD_LOADER_CHECKSUM_EN
    .checksum     (checksum),
`endif
    .busy         (busy),
    .done         (done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_outputs();
    chk("step", 32'(step), 32'(e_step));
    chk("bram_num", 32'(bram_num), 32'(e_num));
    chk("bram_layer", 32'(bram_layer), 32'(e_layer));
    chk("bram_addr", 32'(bram_addr), 32'(e_addr));
    chk("data_received", data_received, e_data);
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("done", 32'(done), 32'(m_phase == 2));
`ifdef SCRATCH_PAD_LOADER_CHECKSUM_EN
    chk("checksum", checksum, m_sum);
`endif
    if (done === 1'b1) done_cnt++;
  endtask
  task automatic cycle(input logic st, input logic lw, input logic ab, input logic v, input logic [31:0] d);
    logic hs;
    int total;
    start = st;
    load_weight = lw;
    abort = ab;
    s_valid = v;
    s_data = d;
    #1;
    chk("s_ready", 32'(s_ready), 32'(m_phase == 1 && !ab));
    hs = m_phase == 1 && v && !ab;
    total = (m_mode ? 64 : 1) * 5 * 2;
    e_step = hs ? (m_mode ? 2 : 1) : 0;
    if (hs) begin
      e_num = m_k / 10;
      e_layer = (m_k / 2) % 5;
      e_addr = m_k % 2;
      e_data = d;
      m_sum = m_sum + d;
    end
    if (m_phase == 0) begin
      if (st) begin
        m_phase = 1;
        m_mode = lw;
        m_k = 0;
        m_sum = '0;
      end
    end else if (m_phase == 1) begin
      if (ab) begin
        m_phase = 0;
        m_k = 0;
      end else if (hs) begin
        m_k++;
        if (m_k == total) m_phase = 2;
      end
    end else m_phase = 0;
    @(posedge clk);
    #1;
    chk_outputs();
  endtask
  initial begin
    #1;
    chk_outputs();
    chk("reset_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(0, 0, 0, 1, 32'hdead);
    cycle(0, 0, 1, 1, 32'hbeef);
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 40 && m_phase != 0; i++) cycle(0, 0, 0, 1, 32'h100 + 32'(m_k));
    chk("act_idle", 32'(busy), 32'd0);
    done_cnt = 0;
    cycle(1, 1, 0, 0, 0);
    for (int i = 0; i < 3000 && m_phase != 0; i++)
      cycle(i == 300 || m_phase == 2, 1'($urandom % 2), 0, 1'(i % 2), $urandom);
    chk("wgt_last_num", 32'(bram_num), 32'd63);
    chk("wgt_last_layer", 32'(bram_layer), 32'd4);
    chk("wgt_last_addr", 32'(bram_addr), 32'd1);
    chk("wgt_done_count", 32'(done_cnt), 32'd1);
    cycle(1, 0, 0, 0, 0);
    chk("restart_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 40 && m_phase != 0; i++) cycle(0, 0, m_k == 5, 1, $urandom);
    chk("abort_idle", 32'(busy), 32'd0);
    cycle(0, 0, 0, 1, $urandom);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h55);
    chk("restart_layer", 32'(bram_layer), 32'd0);
    chk("restart_addr", 32'(bram_addr), 32'd0);
    for (int i = 0; i < 80 && m_phase != 0; i++) cycle(0, 0, 0, 1'($urandom % 2), $urandom);
    chk("act2_idle", 32'(busy), 32'd0);
    cycle(1, 1, 0, 0, 0);
    for (int i = 0; i < 40 && m_k < 3; i++) cycle(0, 0, 0, 1, $urandom);
    rst_n = 1'b0;
    #1;
    m_phase = 0;
    m_k = 0;
    m_mode = 1'b0;
    m_sum = '0;
    e_step = 0;
    e_num = 0;
    e_layer = 0;
    e_addr = 0;
    e_data = '0;
    chk_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(0, 0, 0, 1, 32'h1234);
    cycle(0, 0, 0, 1, 32'h5678);
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 40 && m_phase != 2; i++) cycle(0, 0, 0, 1, 32'(m_k) + 32'd1);
`ifdef SCRATCH_PAD_LOADER_CHECKSUM_EN
    chk("checksum_55", checksum, 32'd55);
`endif
    chk("cks_done", 32'(done), 32'd1);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
`ifdef SCRATCH_PAD_LOADER_CHECKSUM_EN
    chk("checksum_clear", checksum, 32'd0);
`endif
    for (int i = 0; i < 40 && m_phase != 0; i++) cycle(0, 0, 0, 1, $urandom);
    chk("final_idle", 32'(busy), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
